// File: rtl/spi_regfile_periph.sv
// SPI register-file peripheral: synchronised SPI inputs, parametrised register bank, all four SPI modes.
// Optional CIPO readback is compiled in with `define SPI_READBACK_EN; otherwise CIPO/cipo_oe are tied low.
module spi_regfile_periph #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic SCLK_IDLE = 1'(CPOL);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;
  state_t state_q, state_d;

  logic sclk_s1, sclk_s2, sclk_s3, copi_s1, copi_s2, ncs_s1, ncs_s2;
  logic rise, fall, sample_edge, take_bit, hdr_done;
  logic commit_ok, commit_bad;
  logic [FRAME_LEN-1:0]        shift_q, shift_next;
  logic [CNT_W-1:0]            cnt_q;
  logic                        rw_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [NUM_REGS-1:0]         hit;
  logic [NUM_REGS*DATA_W-1:0]  regs_q;

  // Synchronisers reset to the bus idle levels so a reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1 <= SCLK_IDLE;
      sclk_s2 <= SCLK_IDLE;
      sclk_s3 <= SCLK_IDLE;
      copi_s1 <= 1'b0;
      copi_s2 <= 1'b0;
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      copi_s1 <= COPI;
      copi_s2 <= copi_s1;
      ncs_s1  <= nCS;
      ncs_s2  <= ncs_s1;
    end
  end

  assign rise        = sclk_s2 & ~sclk_s3;
  assign fall        = ~sclk_s2 & sclk_s3;
  assign sample_edge = (CPOL == CPHA) ? rise : fall;
  assign take_bit    = sample_edge & ~ncs_s2;
  assign shift_next  = {shift_q[FRAME_LEN-2:0], copi_s2};
  assign hdr_done    = (state_q == ADDR) && take_bit && (cnt_q == CNT_HDR);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A synchronised nCS rise takes priority over a coincident sample edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ncs_s2) state_d = ADDR;
      ADDR:    if (ncs_s2) state_d = COMMIT;
               else if (hdr_done) state_d = DATA;
      DATA:    if (ncs_s2) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    if (state_q == COMMIT) begin
      commit_ok  = (cnt_q == CNT_FULL) && rw_q;
      commit_bad = (cnt_q != CNT_FULL);
    end
  end

  // Out-of-range addresses match no bit, so such writes drop out naturally.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == ADDR_W'(i)) hit[i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      regs_q    <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= commit_bad;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          shift_q <= '0;
        end
        ADDR, DATA: if (take_bit) begin
          shift_q <= shift_next;
          if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          if (hdr_done) begin
            rw_q   <= shift_next[ADDR_W];
            addr_q <= shift_next[ADDR_W-1:0];
          end
        end
        COMMIT: if (commit_ok) begin
          wr_strobe <= hit;
          for (int i = 0; i < NUM_REGS; i++)
            if (hit[i]) regs_q[i*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign regs_flat = regs_q;

`ifdef SPI_READBACK_EN
  logic drive_edge, cipo_q;
  logic [DATA_W-1:0] tx_q, rd_val;

  assign drive_edge = (CPOL == CPHA) ? fall : rise;

  // Read mux looks at the address that is being completed this cycle.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (state_q == IDLE) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
    end else if (hdr_done) begin
      tx_q <= shift_next[ADDR_W] ? '0 : rd_val;
    end else if ((state_q == DATA) && !rw_q && drive_edge && !ncs_s2) begin
      cipo_q <= tx_q[DATA_W-1];
      tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo_oe = (state_q == DATA) && !rw_q;
  assign CIPO    = cipo_oe & cipo_q;
`else
  assign cipo_oe = 1'b0;
  assign CIPO    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: five instances (four SPI modes at default size, one wide config)
// share a bit-banged SPI driver; a monitor pops expected write/error events from a queue.
module tb_spi_regfile_periph;

  localparam int H = 5;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic phase = 1'b0;
  logic copi = 1'b0;
  logic [4:0] ncs = '1;
  logic [4:0] cipo, oe, fe;
  logic [39:0] rf0, rf1, rf2, rf3;
  logic [255:0] rf4;
  logic [4:0] ws0, ws1, ws2, ws3;
  logic [15:0] ws4;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  spi_regfile_periph #(.CPOL(0), .CPHA(0)) u0 (.clk(clk), .rst_n(rst_n), .SCLK(phase), .COPI(copi),
    .nCS(ncs[0]), .CIPO(cipo[0]), .cipo_oe(oe[0]), .regs_flat(rf0), .wr_strobe(ws0), .frame_err(fe[0]));
  spi_regfile_periph #(.CPOL(0), .CPHA(1)) u1 (.clk(clk), .rst_n(rst_n), .SCLK(phase), .COPI(copi),
    .nCS(ncs[1]), .CIPO(cipo[1]), .cipo_oe(oe[1]), .regs_flat(rf1), .wr_strobe(ws1), .frame_err(fe[1]));
  spi_regfile_periph #(.CPOL(1), .CPHA(0)) u2 (.clk(clk), .rst_n(rst_n), .SCLK(~phase), .COPI(copi),
    .nCS(ncs[2]), .CIPO(cipo[2]), .cipo_oe(oe[2]), .regs_flat(rf2), .wr_strobe(ws2), .frame_err(fe[2]));
  spi_regfile_periph #(.CPOL(1), .CPHA(1)) u3 (.clk(clk), .rst_n(rst_n), .SCLK(~phase), .COPI(copi),
    .nCS(ncs[3]), .CIPO(cipo[3]), .cipo_oe(oe[3]), .regs_flat(rf3), .wr_strobe(ws3), .frame_err(fe[3]));
  spi_regfile_periph #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) u4 (.clk(clk), .rst_n(rst_n),
    .SCLK(phase), .COPI(copi), .nCS(ncs[4]), .CIPO(cipo[4]), .cipo_oe(oe[4]), .regs_flat(rf4),
    .wr_strobe(ws4), .frame_err(fe[4]));

  function automatic int cpha_of(input int d);
    return (d == 1 || d == 3) ? 1 : 0;
  endfunction

  function automatic logic [15:0] strobe_of(input int d);
    case (d)
      0: return {11'b0, ws0};
      1: return {11'b0, ws1};
      2: return {11'b0, ws2};
      3: return {11'b0, ws3};
      default: return ws4;
    endcase
  endfunction

  function automatic logic [15:0] reg_of(input int d, input int a);
    case (d)
      0: return {8'b0, rf0[a*8 +: 8]};
      1: return {8'b0, rf1[a*8 +: 8]};
      2: return {8'b0, rf2[a*8 +: 8]};
      3: return {8'b0, rf3[a*8 +: 8]};
      default: return rf4[a*16 +: 16];
    endcase
  endfunction

  function automatic logic [63:0] mk_evt(input int d, input logic [15:0] s, input logic e,
                                         input logic [15:0] v);
    return {8'(d), s, e, 23'b0, v};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe or frame_err cycle must match the next expected event.
  always @(negedge clk) begin : monitor
    logic [15:0] s, v;
    logic [63:0] obs, exp_v;
    if (rst_n) begin
      for (int d = 0; d < 5; d++) begin
        s = strobe_of(d);
        if (s != 16'h0 || fe[d]) begin
          v = 16'h0;
          for (int a = 15; a >= 0; a--)
            if (s[a]) v = reg_of(d, a);
          obs = mk_evt(d, s, fe[d], v);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event inst %0d: got %h required none", d, obs);
          end else begin
            exp_v = exp_q.pop_front();
            if (obs !== exp_v) begin
              n_errors++;
              $display("FAIL event inst %0d: got %h required %h", d, obs, exp_v);
            end
          end
        end
      end
    end
  end

  task automatic spi_bit(input int cpha, input logic b, input int d, output logic rx, output logic oe_s);
    if (cpha == 0) begin
      copi = b;
      repeat (H) @(negedge clk);
      rx = cipo[d]; oe_s = oe[d];
      phase = 1'b1;
      repeat (H) @(negedge clk);
      phase = 1'b0;
    end else begin
      phase = 1'b1;
      copi = b;
      repeat (H) @(negedge clk);
      rx = cipo[d]; oe_s = oe[d];
      phase = 1'b0;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic spi_frame(input int d, input logic [31:0] bits, input int len,
                           output logic [31:0] rx_w, output logic [31:0] oe_w);
    logic r, o;
    rx_w = '0; oe_w = '0;
    ncs[d] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = len - 1; i >= 0; i--) begin
      spi_bit(cpha_of(d), bits[i], d, r, o);
      rx_w = {rx_w[30:0], r};
      oe_w = {oe_w[30:0], o};
    end
    repeat (H) @(negedge clk);
    ncs[d] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rx_w, oe_w;
    logic [15:0] exp_rx, exp_oe;
    logic [255:0] exp_rf4;
    logic r, o;

    repeat (4) @(negedge clk);
    check("reset_rf0", rf0, 0);
    check("reset_rf1_rf3", {rf1, rf2, rf3}, 0);
    check("reset_rf4", rf4, 0);
    check("reset_strobe", {ws0, ws1, ws2, ws3, ws4}, 0);
    check("reset_frame_err", fe, 0);
    check("reset_cipo_oe", {cipo, oe}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Abort a frame part-way with a 2-cycle reset; no event and no register change expected.
    ncs[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 15; i > 10; i--) spi_bit(0, 1'b1, 0, r, o);
    rst_n = 1'b0;
    ncs[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midframe_reset_regs", rf0, 0);
    check("midframe_reset_oe", oe[0], 0);

    exp_q.push_back(mk_evt(0, 16'h0004, 1'b0, 16'h0055));
    spi_frame(0, 32'h8255, 16, rx_w, oe_w);
    check("write_reg2", rf0, 40'h00_00_55_00_00);

    exp_q.push_back(mk_evt(0, 16'h0002, 1'b0, 16'h003C));
    spi_frame(0, 32'h813C, 16, rx_w, oe_w);
    check("write_reg1", rf0, 40'h00_00_55_3C_00);

`ifdef SPI_READBACK_EN
    exp_rx = 16'h003C; exp_oe = 16'h00FF;
`else
    exp_rx = 16'h0000; exp_oe = 16'h0000;
`endif
    spi_frame(0, 32'h0100, 16, rx_w, oe_w);
    check("read_reg1_cipo", rx_w[15:0], exp_rx);
    check("read_reg1_oe", oe_w[15:0], exp_oe);
    check("read_no_side_effect", rf0, 40'h00_00_55_3C_00);
    check("idle_cipo_oe", {cipo[0], oe[0]}, 0);

    exp_q.push_back(mk_evt(0, 16'h0000, 1'b1, 16'h0000));
    spi_frame(0, 32'h80FF >> 1, 15, rx_w, oe_w);
    check("short_frame_regs", rf0, 40'h00_00_55_3C_00);

    exp_q.push_back(mk_evt(0, 16'h0000, 1'b1, 16'h0000));
    spi_frame(0, 32'h80FF << 1, 17, rx_w, oe_w);
    check("long_frame_regs", rf0, 40'h00_00_55_3C_00);

    spi_frame(0, 32'h8711, 16, rx_w, oe_w);
    check("oor_write_regs", rf0, 40'h00_00_55_3C_00);
    spi_frame(0, 32'h0700, 16, rx_w, oe_w);
    check("oor_read_cipo", rx_w[15:0], 16'h0000);
    check("oor_read_oe", oe_w[15:0], exp_oe);

    for (int d = 0; d < 4; d++) begin
      exp_q.push_back(mk_evt(d, 16'h0010, 1'b0, 16'h00A7));
      spi_frame(d, 32'h84A7, 16, rx_w, oe_w);
    end
    check("mode00_reg4", rf0, 40'hA7_00_55_3C_00);
    check("mode01_reg4", rf1, 40'hA7_00_00_00_00);
    check("mode10_reg4", rf2, 40'hA7_00_00_00_00);
    check("mode11_reg4", rf3, 40'hA7_00_00_00_00);

    exp_q.push_back(mk_evt(4, 16'h8000, 1'b0, 16'hBEEF));
    spi_frame(4, 32'h1FBEEF, 21, rx_w, oe_w);
    exp_rf4 = '0;
    exp_rf4[255:240] = 16'hBEEF;
    check("wide_reg15", rf4, exp_rf4);

    repeat (10) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
